// File: rtl/pipe_pkg.sv
// Shared constants for pipeline-stage registers: state encodings and default datapath width.
package pipe_pkg;
  localparam int XLEN = 32;

  // The state is the pair {skid_valid, main_valid}.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b11;

  function automatic logic [1:0] occ_of(input logic [1:0] st);
    return {1'b0, st[1]} + {1'b0, st[0]};
  endfunction
endpackage

// File: rtl/pipe_data_reg.sv
// Payload register with load enable and a synchronous active-low reset to a programmable value.
module pipe_data_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (!reset)  q <= RESET_VAL;
    else if (en) q <= d;
  end
endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake and a 2-entry skid buffer.
// in_ready is taken straight from a flop, so no ready path crosses stages combinationally.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = XLEN,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);
  logic [1:0]       st_q, st_d;
  logic [1:0]       occ_q;
  logic             main_en, skid_en;
  logic [WIDTH-1:0] main_d, main_q, skid_q;
  logic             acc_in, acc_out;

  assign in_ready  = ~st_q[1];
  assign out_valid = st_q[0];
  assign out_data  = main_q;
  assign occupancy = occ_q;
  assign acc_in    = in_valid & in_ready;
  assign acc_out   = out_valid & out_ready;

  always_comb begin
    st_d    = st_q;
    main_en = 1'b0;
    skid_en = 1'b0;
    main_d  = in_data;
    unique case (st_q)
      ST_EMPTY: begin
        if (acc_in) begin
          st_d    = ST_BUSY;
          main_en = 1'b1;
        end
      end
      ST_BUSY: begin
        if (acc_in && acc_out) begin
          main_en = 1'b1;
        end else if (acc_in) begin
          st_d    = ST_FULL;
          skid_en = 1'b1;
        end else if (acc_out) begin
          st_d    = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (acc_out) begin
          st_d    = ST_BUSY;
          main_en = 1'b1;
          main_d  = skid_q;
        end
      end
      default: st_d = ST_EMPTY;
    endcase
    // Flush only kills the valid bits; payload registers keep their contents.
    if (flush) begin
      st_d    = ST_EMPTY;
      main_en = 1'b0;
      skid_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      st_q  <= ST_EMPTY;
      occ_q <= 2'd0;
    end else begin
      st_q  <= st_d;
      occ_q <= occ_of(st_d);
    end
  end

  pipe_data_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
    .clk(clk), .reset(reset), .en(main_en), .d(main_d), .q(main_q)
  );

  pipe_data_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
    .clk(clk), .reset(reset), .en(skid_en), .d(in_data), .q(skid_q)
  );
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and scoreboarded random checks of pipe_stage_reg at WIDTH=8, RESET_VAL=8'hA5.
module tb_pipe_stage_reg;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, flush, in_valid, out_ready;
  logic [W-1:0] in_data;
  logic         in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;

  int n_total = 0;
  int n_pass  = 0;

  pipe_stage_reg #(.WIDTH(W), .RESET_VAL(8'hA5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_outs(input string tag, input logic ov, input logic ir,
                          input logic [W-1:0] od, input logic [1:0] oc);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, ".in_ready"},  32'(in_ready),  32'(ir));
    chk({tag, ".out_data"},  32'(out_data),  32'(od));
    chk({tag, ".occupancy"}, 32'(occupancy), 32'(oc));
  endtask

  initial begin
    logic [W-1:0] sb[$];
    logic [W-1:0] nxt_val, exp_v, held;
    logic         stalled, acc_i, acc_o;

    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    step(); step();
    chk_outs("reset", 1'b0, 1'b1, 8'hA5, 2'd0);
    reset = 1'b1;

    // Streaming at one beat per cycle
    in_valid = 1'b1; out_ready = 1'b1;
    in_data = 8'h01; step(); chk_outs("stream1", 1'b1, 1'b1, 8'h01, 2'd1);
    in_data = 8'h02; step(); chk_outs("stream2", 1'b1, 1'b1, 8'h02, 2'd1);
    in_data = 8'h03; step(); chk_outs("stream3", 1'b1, 1'b1, 8'h03, 2'd1);
    in_valid = 1'b0; step(); chk_outs("drain", 1'b0, 1'b1, 8'h03, 2'd0);

    // Backpressure fills the skid entry
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 8'h10; step(); chk_outs("bp1", 1'b1, 1'b1, 8'h10, 2'd1);
    in_data = 8'h11; step(); chk_outs("bp_full", 1'b1, 1'b0, 8'h10, 2'd2);
    in_data = 8'h12; step(); chk_outs("bp_hold", 1'b1, 1'b0, 8'h10, 2'd2);
    in_valid = 1'b0; out_ready = 1'b1;
    step(); chk_outs("bp_drain1", 1'b1, 1'b1, 8'h11, 2'd1);
    step(); chk_outs("bp_drain2", 1'b0, 1'b1, 8'h11, 2'd0);

    // Flush in FULL discards the offered beat
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 8'h20; step();
    in_data = 8'h21; step(); chk_outs("fl_full", 1'b1, 1'b0, 8'h20, 2'd2);
    flush = 1'b1; in_data = 8'h22; step();
    chk_outs("flush_full", 1'b0, 1'b1, 8'h20, 2'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; step();
    chk_outs("post_flush", 1'b0, 1'b1, 8'h20, 2'd0);

    // Flush in BUSY while a beat is accepted: beat dropped, data reg untouched
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h30; step();
    flush = 1'b1; in_data = 8'h31; step();
    chk_outs("flush_busy", 1'b0, 1'b1, 8'h30, 2'd0);
    flush = 1'b0; in_valid = 1'b0;

    // Reset mid-operation beats flush and handshakes
    in_valid = 1'b1; in_data = 8'h40; step();
    in_data = 8'h41; step(); chk_outs("rst_full", 1'b1, 1'b0, 8'h40, 2'd2);
    reset = 1'b0; flush = 1'b1; in_data = 8'h42; step();
    chk_outs("rst_mid", 1'b0, 1'b1, 8'hA5, 2'd0);
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; step();
    chk_outs("rst_rel", 1'b0, 1'b1, 8'hA5, 2'd0);

    // Random valid/ready against a FIFO scoreboard
    nxt_val = 8'h00; stalled = 1'b0; held = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!(in_valid && !in_ready)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = nxt_val;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      acc_i = in_valid & in_ready;
      acc_o = out_valid & out_ready;
      if (acc_o) begin
        if (sb.size() == 0) chk("rnd_spurious", 32'(out_valid), 32'(0));
        else begin
          exp_v = sb.pop_front();
          chk("rnd_order", 32'(out_data), 32'(exp_v));
        end
      end
      if (acc_i) begin
        sb.push_back(in_data);
        nxt_val = nxt_val + 8'd1;
      end
      stalled = out_valid & ~out_ready;
      held    = out_data;
      step();
      if (stalled) begin
        chk("rnd_stall_valid", 32'(out_valid), 32'(1));
        chk("rnd_stall_data",  32'(out_data),  32'(held));
      end
      chk("rnd_occ", 32'(occupancy), 32'(sb.size()));
    end

    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (out_valid) begin
        if (sb.size() == 0) chk("drain_spurious", 32'(out_valid), 32'(0));
        else begin
          exp_v = sb.pop_front();
          chk("drain_order", 32'(out_data), 32'(exp_v));
        end
      end
      step();
    end
    chk("drain_empty", 32'(sb.size()), 32'(0));
    chk("drain_valid", 32'(out_valid), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
